lcd_bus_responder: RTL

HD44780-compatible bus responder: the LCD-module side of the RS/RW/E/D[7:0] parallel interface that our LCD connection block drives. It samples E asynchronously, decodes instructions and data writes into a 128-byte DDRAM, enforces busy time, and answers busy-flag and data reads. It serves as the on-chip display target for menu-code bring-up and as the bench model for the LCD driver.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_ddram.sv | 26 ++
 rtl/lcd_bus_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and address helper for the HD44780-style bus responder.
package lcd_pkg;

    localparam logic [7:0] CMD_CLR     = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPCTL = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    localparam logic [7:0] CHAR_SPACE  = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_WAIT = 2'd2
    } lcd_state_t;

    // 7-bit step that wraps naturally 127->0 and 0->127.
    function automatic logic [6:0] step7(input logic [6:0] v, input logic up);
        return up ? (v + 7'd1) : (v - 7'd1);
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 128x8 display RAM: one synchronous write port, two combinational read ports.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [6:0] raddr_b,
    output logic [7:0] rdata_b
);

    logic [7:0] mem [128];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/lcd_bus_responder.sv
// LCD-module side of the RS/RW/E/D bus: synchronizes E, decodes instructions and
// data accesses into DDRAM, models busy time and answers busy-flag/data reads.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int CMD_CYCLES   = 1850,
    parameter int CLEAR_CYCLES = 76000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic [6:0] addr_counter,
    output logic       entry_id,
    output logic       entry_s,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [6:0] disp_offset,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy_violation
);

    localparam int MAXC = (CMD_CYCLES > CLEAR_CYCLES) ? CMD_CYCLES : CLEAR_CYCLES;
    localparam int CW   = $clog2(MAXC);

    logic       en_s1, en_s2, en_s3;
    logic       rs_s1, rs_s2;
    logic       rw_s1, rw_s2;
    logic [7:0] d_s1, d_s2;
    logic       rise, fall;

    lcd_state_t  state;
    logic [CW-1:0] cnt;
    logic [6:0]  fill_idx;

    logic       ddr_we;
    logic [6:0] ddr_waddr;
    logic [7:0] ddr_wdata;
    logic [7:0] ac_char;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_s1 <= 1'b0; en_s2 <= 1'b0; en_s3 <= 1'b0;
            rs_s1 <= 1'b0; rs_s2 <= 1'b0;
            rw_s1 <= 1'b0; rw_s2 <= 1'b0;
            d_s1  <= '0;   d_s2  <= '0;
        end else begin
            en_s1 <= lcd_en;      en_s2 <= en_s1; en_s3 <= en_s2;
            rs_s1 <= lcd_rs;      rs_s2 <= rs_s1;
            rw_s1 <= lcd_rw;      rw_s2 <= rw_s1;
            d_s1  <= lcd_data_in; d_s2  <= d_s1;
        end
    end

    assign rise = en_s2 & ~en_s3;
    assign fall = en_s3 & ~en_s2;
    assign busy = (state != ST_IDLE);

    // Fill and host writes never coincide: host writes are only accepted when idle.
    always_comb begin
        ddr_we    = 1'b0;
        ddr_waddr = addr_counter;
        ddr_wdata = d_s2;
        if (!rst) begin
            if (state == ST_FILL) begin
                ddr_we    = 1'b1;
                ddr_waddr = fill_idx;
                ddr_wdata = CHAR_SPACE;
            end else if (fall && !rw_s2 && rs_s2 && state == ST_IDLE) begin
                ddr_we = 1'b1;
            end
        end
    end

    lcd_ddram u_ddram (
        .clk     (clk),
        .we      (ddr_we),
        .waddr   (ddr_waddr),
        .wdata   (ddr_wdata),
        .raddr_a (addr_counter),
        .rdata_a (ac_char),
        .raddr_b (rd_addr),
        .rdata_b (rd_char)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            fill_idx       <= '0;
            addr_counter   <= '0;
            entry_id       <= 1'b1;
            entry_s        <= 1'b0;
            disp_on        <= 1'b0;
            cursor_on      <= 1'b0;
            blink_on       <= 1'b0;
            disp_offset    <= '0;
            lcd_data_out   <= '0;
            lcd_data_oe    <= 1'b0;
            busy_violation <= 1'b0;
        end else begin
            busy_violation <= 1'b0;

            case (state)
                ST_FILL: begin
                    fill_idx <= fill_idx + 7'd1;
                    // 128 fill cycles already spent; remainder keeps total busy at CLEAR_CYCLES.
                    if (fill_idx == 7'd127) begin
                        state <= ST_WAIT;
                        cnt   <= CW'(CLEAR_CYCLES - 129);
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) state <= ST_IDLE;
                    else           cnt   <= cnt - CW'(1);
                end
                default: ;
            endcase

            if (rise && rw_s2) begin
                lcd_data_out <= rs_s2 ? ac_char : {busy, addr_counter};
                lcd_data_oe  <= 1'b1;
            end

            if (fall) begin
                lcd_data_oe <= 1'b0;
                if (!rw_s2) begin
                    if (busy) begin
                        busy_violation <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                        cnt   <= CW'(CMD_CYCLES - 1);
                        if (rs_s2) begin
                            addr_counter <= step7(addr_counter, entry_id);
                            if (entry_s) disp_offset <= step7(disp_offset, entry_id);
                        end else if (|(d_s2 & CMD_DDRAM)) begin
                            addr_counter <= d_s2[6:0];
                        end else if (|(d_s2 & CMD_CGRAM)) begin
                        end else if (|(d_s2 & CMD_FUNC)) begin
                        end else if (|(d_s2 & CMD_SHIFT)) begin
                            if (d_s2[3]) disp_offset  <= step7(disp_offset, d_s2[2]);
                            else         addr_counter <= step7(addr_counter, d_s2[2]);
                        end else if (|(d_s2 & CMD_DISPCTL)) begin
                            disp_on   <= d_s2[2];
                            cursor_on <= d_s2[1];
                            blink_on  <= d_s2[0];
                        end else if (|(d_s2 & CMD_ENTRY)) begin
                            entry_id <= d_s2[1];
                            entry_s  <= d_s2[0];
                        end else if (|(d_s2 & CMD_HOME)) begin
                            addr_counter <= '0;
                            disp_offset  <= '0;
                            cnt          <= CW'(CLEAR_CYCLES - 1);
                        end else if (|(d_s2 & CMD_CLR)) begin
                            addr_counter <= '0;
                            disp_offset  <= '0;
                            entry_id     <= 1'b1;
                            fill_idx     <= '0;
                            state        <= ST_FILL;
                        end
                    end
                end else if (rs_s2 && !busy) begin
                    addr_counter <= step7(addr_counter, entry_id);
                    state        <= ST_WAIT;
                    cnt          <= CW'(CMD_CYCLES - 1);
                end
            end
        end
    end

endmodule
